// File: rtl/cpu_parameters.sv
// Shared CPU-wide constants and types used by the instruction-fetch stage.
package cpu_parameters;

    localparam int unsigned xlen = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        HOLD = 2'b11
    } ifetch_state_t;

    // An instruction address must be word aligned; low two bits flag a misaligned fetch.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, holds the returned word
// until the PC generator accepts it, and discards responses killed by a flush.
module ifetch_unit
    import cpu_parameters::*;
#(
    parameter int unsigned XLEN      = cpu_parameters::xlen,
    parameter logic [31:0] NOP_INSTR = cpu_parameters::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] next_pc,
    input  logic            next_pc_valide,
    input  logic            flush,
    output logic [31:0]     instruction,
    output logic            instr_valid,
    input  logic            ok_i,
    output logic [XLEN-1:0] fetch_pc,
    output logic            misaligned,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata
);

    ifetch_state_t   r_state;
    logic [XLEN-1:0] r_addr;
    logic [31:0]     r_instruction;
    logic            r_instr_valid;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_misaligned;
    logic            r_kill;
    logic            r_imem_req;
    logic [XLEN-1:0] r_imem_addr;

    ifetch_state_t   w_state_next;
    logic            w_mis;
    logic            w_in_flight;
    logic            w_data;
    logic            w_flush_kill;
    logic            w_kill_next;
    logic            w_launch_req;
    logic            w_load_data;
    logic            w_load_mis;
    logic            w_clear_out;

    // Response qualification: a live rvalid only counts once our request is granted.
    always_comb begin
        w_mis        = is_misaligned(next_pc[1:0]);
        w_in_flight  = (r_state == WAIT) || ((r_state == REQ) && imem_gnt);
        w_data       = imem_rvalid && !r_kill && w_in_flight;
        // A flush that leaves a granted request unanswered must swallow its response.
        w_flush_kill = flush && w_in_flight && !w_data;
        if (w_flush_kill) begin
            w_kill_next = 1'b1;
        end else if (imem_rvalid && r_kill) begin
            w_kill_next = 1'b0;
        end else begin
            w_kill_next = r_kill;
        end
    end

    // Next-state and datapath load controls; flush overrides every other event.
    always_comb begin
        w_state_next = r_state;
        w_launch_req = 1'b0;
        w_load_data  = 1'b0;
        w_load_mis   = 1'b0;
        w_clear_out  = 1'b0;
        if (flush) begin
            w_clear_out = 1'b1;
            if (next_pc_valide) begin
                w_state_next = REQ;
                w_launch_req = 1'b1;
            end else begin
                w_state_next = IDLE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (next_pc_valide) begin
                        if (w_mis) begin
                            w_state_next = HOLD;
                            w_load_mis   = 1'b1;
                        end else begin
                            w_state_next = REQ;
                            w_launch_req = 1'b1;
                        end
                    end else begin
                        w_state_next = IDLE;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        if (w_data) begin
                            w_state_next = HOLD;
                            w_load_data  = 1'b1;
                        end else begin
                            w_state_next = WAIT;
                        end
                    end else begin
                        w_state_next = REQ;
                    end
                end
                WAIT: begin
                    if (w_data) begin
                        w_state_next = HOLD;
                        w_load_data  = 1'b1;
                    end else begin
                        w_state_next = WAIT;
                    end
                end
                HOLD: begin
                    if (ok_i) begin
                        w_clear_out = 1'b1;
                        if (next_pc_valide) begin
                            w_state_next = REQ;
                            w_launch_req = 1'b1;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_state_next = HOLD;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // FSM state, kill flag and the registered memory request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_kill      <= 1'b0;
            r_imem_req  <= 1'b0;
            r_imem_addr <= {XLEN{1'b0}};
            r_addr      <= {XLEN{1'b0}};
        end else begin
            r_state    <= w_state_next;
            r_kill     <= w_kill_next;
            r_imem_req <= (w_state_next == REQ);
            if (w_launch_req || w_load_mis) begin
                r_addr <= next_pc;
            end else begin
                r_addr <= r_addr;
            end
            if (w_launch_req) begin
                r_imem_addr <= next_pc;
            end else begin
                r_imem_addr <= r_imem_addr;
            end
        end
    end

    // Word presented to the PC generator; frozen while held and not accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instruction <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_fetch_pc    <= {XLEN{1'b0}};
            r_misaligned  <= 1'b0;
        end else if (w_load_data) begin
            r_instruction <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_fetch_pc    <= r_addr;
            r_misaligned  <= 1'b0;
        end else if (w_load_mis) begin
            r_instruction <= NOP_INSTR;
            r_instr_valid <= 1'b1;
            r_fetch_pc    <= next_pc;
            r_misaligned  <= 1'b1;
        end else if (w_clear_out) begin
            r_instruction <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_instruction <= r_instruction;
            r_instr_valid <= r_instr_valid;
            r_fetch_pc    <= r_fetch_pc;
            r_misaligned  <= r_misaligned;
        end
    end

    assign instruction = r_instruction;
    assign instr_valid = r_instr_valid;
    assign fetch_pc    = r_fetch_pc;
    assign misaligned  = r_misaligned;
    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit with a transaction-level memory and fetch model.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        next_pc_valide;
    logic        flush;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        ok_i;
    logic [31:0] fetch_pc;
    logic        misaligned;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .next_pc        (next_pc),
        .next_pc_valide (next_pc_valide),
        .flush          (flush),
        .instruction    (instruction),
        .instr_valid    (instr_valid),
        .ok_i           (ok_i),
        .fetch_pc       (fetch_pc),
        .misaligned     (misaligned),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata)
    );

    typedef enum int {P_IDLE, P_BUSY, P_HELD} ph_t;
    typedef struct {logic [31:0] addr; bit killed;} owe_t;
    typedef struct {logic [31:0] pc; logic [31:0] ins; bit mis;} exp_t;

    ph_t  ph;
    ph_t  cur_ph;
    bit   cur_req_exp;
    owe_t owed[$];
    exp_t exp_q[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_consumed = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit owed_has_real();
        foreach (owed[i]) if (!owed[i].killed) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit owed_has_killed();
        foreach (owed[i]) if (owed[i].killed) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: the bench acts as PC generator and as the memory.
    task automatic step();
        bit f, ok, launch, junk, gnt, rv, mis, pair, real_rv;
        logic [31:0] a;
        owe_t e;
        @(posedge clk);
        #1;
        cur_ph      = ph;
        cur_req_exp = (ph == P_BUSY) && !owed_has_real();
        f  = !owed_has_killed() && ($urandom_range(0, 15) == 0);
        ok = !f && (ph == P_HELD) && ($urandom_range(0, 2) == 0);
        if (f || ph == P_IDLE || ok) launch = ($urandom_range(0, 1) == 1);
        else launch = 1'b0;
        mis  = launch && !f && (ph == P_IDLE) && ($urandom_range(0, 5) == 0);
        a    = {16'd0, 14'($urandom), (mis ? 2'($urandom_range(1, 3)) : 2'b00)};
        junk = !f && (ph == P_BUSY || (ph == P_HELD && !ok)) && ($urandom_range(0, 3) == 0);
        if (junk) a = $urandom;
        gnt  = imem_req && (ph == P_BUSY) && ($urandom_range(0, 1) == 1);
        rv   = (owed.size() > 0 || gnt) && ($urandom_range(0, 1) == 1);
        pair = rv && (owed.size() == 0);
        real_rv = 1'b0;
        if (rv) begin
            if (pair) e = '{addr: imem_addr, killed: 1'b0};
            else e = owed.pop_front();
            real_rv    = !e.killed && !f;
            imem_rdata = mem_word(e.addr);
        end else begin
            imem_rdata = $urandom;
        end
        if (gnt && !pair) owed.push_back('{addr: imem_addr, killed: f});
        if (f) begin
            foreach (owed[i]) owed[i].killed = 1'b1;
            exp_q.delete();
            if (launch) begin
                exp_q.push_back('{pc: a, ins: mem_word(a), mis: 1'b0});
                ph = P_BUSY;
            end else begin
                ph = P_IDLE;
            end
        end else begin
            case (ph)
                P_IDLE: if (launch) begin
                    if (mis) begin
                        exp_q.push_back('{pc: a, ins: NOP, mis: 1'b1});
                        ph = P_HELD;
                    end else begin
                        exp_q.push_back('{pc: a, ins: mem_word(a), mis: 1'b0});
                        ph = P_BUSY;
                    end
                end
                P_BUSY: if (real_rv) ph = P_HELD;
                P_HELD: if (ok) begin
                    if (launch) begin
                        exp_q.push_back('{pc: a, ins: mem_word(a), mis: 1'b0});
                        ph = P_BUSY;
                    end else begin
                        ph = P_IDLE;
                    end
                end
                default: ph = P_IDLE;
            endcase
        end
        next_pc        = a;
        next_pc_valide = launch || junk;
        flush          = f;
        ok_i           = ok;
        imem_gnt       = gnt;
        imem_rvalid    = rv;
    endtask

    task automatic idle_inputs();
        next_pc        = 32'h0;
        next_pc_valide = 1'b0;
        flush          = 1'b0;
        ok_i           = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_instruction"}, instruction, NOP);
        chk({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_fetch_pc"}, fetch_pc, 32'd0);
        chk({tag, "_misaligned"}, {31'd0, misaligned}, 32'd0);
        chk({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, 32'd0);
    endtask

    task automatic model_reset();
        ph          = P_IDLE;
        cur_ph      = P_IDLE;
        cur_req_exp = 1'b0;
        owed.delete();
        exp_q.delete();
    endtask

    // Monitor: compares DUT outputs against the scoreboard, popping on each consumption.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, cur_ph == P_HELD});
            chk("imem_req", {31'd0, imem_req}, {31'd0, cur_req_exp});
            if (cur_req_exp && !flush && exp_q.size() > 0) chk("imem_addr", imem_addr, exp_q[0].pc);
            if (cur_ph != P_HELD) begin
                chk("empty_instruction", instruction, NOP);
                chk("empty_misaligned", {31'd0, misaligned}, 32'd0);
            end
            if (cur_ph == P_HELD && ok_i && !flush) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard: consumption with no expected word at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("instruction", instruction, mon_e.ins);
                    chk("fetch_pc", fetch_pc, mon_e.pc);
                    chk("misaligned", {31'd0, misaligned}, {31'd0, mon_e.mis});
                    n_consumed++;
                end
            end
        end
    end

    initial begin
        int tries;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3000) step();
        chk("progress", {31'd0, n_consumed > 100}, 32'd1);

        // Asynchronous reset while a granted request is awaiting its response.
        tries = 0;
        while (!(ph == P_BUSY && owed_has_real()) && tries < 1000) begin
            step();
            tries++;
        end
        chk("reach_wait", {31'd0, ph == P_BUSY && owed_has_real()}, 32'd1);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            chk("stale_rvalid_valid", {31'd0, instr_valid}, 32'd0);
            chk("stale_rvalid_req", {31'd0, imem_req}, 32'd0);
            chk("stale_rvalid_instr", instruction, NOP);
            @(posedge clk);
            #1;
        end
        mon_en = 1'b1;
        repeat (600) step();
        @(negedge clk);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage that serves the PC generator.
- Accepts a fetch address and its valid strobe from the PC generator, and issues a single-outstanding request on the instruction-memory bus (req/gnt then rvalid).
- Holds the returned 32-bit word until the PC generator accepts it.
- Handles pipeline flush, including discard of a response already in flight.

Parameters:
- XLEN, default cpu_parameters::xlen (32): address width.
- NOP_INSTR, default 32'h0000_0013: value driven on instruction while no valid word is held.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- next_pc  in  XLEN  fetch address from the PC generator
- next_pc_valide  in  1  next_pc valid this cycle
- flush  in  1  kill the current fetch; the new address arrives via next_pc
- instruction  out  32  fetched word to the PC generator
- instr_valid  out  1  instruction holds a fetched word
- ok_i  in  1  PC generator consumes instruction this cycle
- fetch_pc  out  XLEN  address of the word on instruction
- misaligned  out  1  held word belongs to a misaligned address (next_pc[1:0]!=0)
- imem_req  out  1  memory request
- imem_addr  out  XLEN  request address
- imem_gnt  in  1  request accepted
- imem_rvalid  in  1  response valid
- imem_rdata  in  32  response data

Behaviour:
- Reset is asynchronous and active-low, on a single clock clk. Reset values:
  - state = IDLE
  - imem_req = 0, imem_addr = 0
  - instruction = NOP_INSTR, instr_valid = 0, fetch_pc = 0, misaligned = 0
  - kill = 0
- States:
  - IDLE: no fetch in progress.
  - REQ: imem_req=1 with imem_addr = the latched address.
  - WAIT: granted, awaiting rvalid.
  - HOLD: instr_valid=1, awaiting ok_i.
- IDLE to REQ: when next_pc_valide=1, latch next_pc into addr_q.
  - If next_pc[1:0]!=0, go directly to HOLD instead. instruction=NOP_INSTR, misaligned=1, fetch_pc=next_pc, no bus request.
- REQ:
  - imem_req and imem_addr stay stable until imem_gnt.
  - On gnt, go to WAIT.
  - If gnt and rvalid arrive in the same cycle, capture the data and go straight to HOLD.
- WAIT to HOLD on imem_rvalid: instruction<=imem_rdata, fetch_pc<=addr_q, instr_valid<=1, misaligned<=0.
- HOLD, ok_i=1:
  - instr_valid drops next cycle.
  - If next_pc_valide=1 in the same cycle, go to REQ with the new address (back-to-back, one cycle of bubble). Otherwise go to IDLE.
- HOLD, ok_i=0: all outputs frozen.
- Minimum latency next_pc_valide to instr_valid is 2 cycles (gnt and rvalid both immediate).
- Flush takes priority over every other event in all states:
  - instr_valid<=0, instruction<=NOP_INSTR.
  - If next_pc_valide is also 1, restart in REQ with next_pc. Otherwise go to IDLE.
  - Flush in REQ before gnt: drop imem_req the next cycle. The bus tolerates a withdrawn ungranted request.
  - Flush in WAIT, or in REQ with gnt that cycle: set kill=1. The next imem_rvalid is consumed and discarded, then kill=0.
  - While kill=1, a new request may be issued, but its response is the one after the killed one.
  - Flush coinciding with rvalid in WAIT: the data is discarded and kill is not set.
- next_pc_valide outside IDLE, HOLD+ok_i, or flush is ignored.
- Only one request is outstanding at a time; no address arithmetic is done here.

Decomposition:
- Shared package cpu_parameters:
  - xlen
  - NOP_INSTR constant
  - ifetch_state_t enum {IDLE, REQ, WAIT, HOLD}
- No sub-module needed. The datapath registers (addr_q, instruction, fetch_pc, kill) and the FSM sit in one module.

Test Plan:
- Basic fetch: next_pc=0x1000 valid, gnt immediate, rvalid one cycle later with 0x00500093 → imem_addr=0x1000; instruction=0x00500093, fetch_pc=0x1000, instr_valid=1 in cycle 2; held until ok_i.
- Backpressure: ok_i held 0 for 5 cycles in HOLD → instruction/fetch_pc stable, no new imem_req. ok_i=1 with next_pc=0x1004 valid → REQ on 0x1004 the next cycle.
- Stalled grant: gnt withheld 3 cycles → imem_req=1 and imem_addr=0x2000 constant throughout; rvalid 0xDEADBEEF arrives after gnt → instruction=0xDEADBEEF.
- Flush in WAIT: fetch 0x3000 granted, flush with next_pc=0x4000 valid → request for 0x4000 issued; first rvalid (0x11111111) discarded; second rvalid 0x22222222 → instruction=0x22222222, fetch_pc=0x4000.
- Misaligned: next_pc=0x1002 valid → no imem_req; next cycle instr_valid=1, misaligned=1, instruction=0x00000013, fetch_pc=0x1002.
- Reset mid-operation: rst_n low while in WAIT → outputs return to reset values immediately (asynchronous); the stale rvalid after release is ignored because state is IDLE.
